// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-ported line RAM between two cache ports.
// Each grant performs one whole-line access and returns a response before the next grant.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LINE_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LINE_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [LINE_W-1:0] rsp_data,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_addr_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data_valid,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic              ram_data_ready,
  input  logic [LINE_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant0, grant1;
  logic              we_p1, id_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [LINE_W-1:0] wdata_p1;
  logic [LINE_W-1:0] rsp_data_p2;
  logic              in_access;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        // On contention the port that did not win last time goes first.
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
        if (grant0 || grant1) state_nxt = ACCESS;
      end
      ACCESS: if (ram_data_ready) state_nxt = RESP;
      RESP: if ((!id_p1 && rsp0_ready) || (id_p1 && rsp1_ready)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == RESP && state_nxt == IDLE) last_grant <= id_p1;
    end
  end

  // Stage p1: request fields latched at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      id_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (grant0 || grant1) begin
      we_p1    <= grant1 ? req1_we    : req0_we;
      id_p1    <= grant1;
      addr_p1  <= grant1 ? req1_addr  : req0_addr;
      wdata_p1 <= grant1 ? req1_wdata : req0_wdata;
    end
  end

  // Stage p2: response line captured on the RAM handshake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_p2 <= '0;
    end else if (in_access && ram_data_ready) begin
      rsp_data_p2 <= we_p1 ? wdata_p1 : ram_rdata;
    end
  end

  // RAM pins are decoded from state so reset drops chip select without waiting for a clock.
  assign in_access      = (state == ACCESS);
  assign ram_cs         = in_access;
  assign ram_addr_valid = in_access;
  assign ram_we         = in_access && we_p1;
  assign ram_data_valid = in_access && we_p1;
  assign ram_addr       = in_access ? addr_p1  : '0;
  assign ram_wdata      = in_access ? wdata_p1 : '0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == RESP) && !id_p1;
  assign rsp1_valid = (state == RESP) && id_p1;
  assign rsp_data   = rsp_data_p2;
  assign busy       = (state != IDLE);

endmodule
